adaptive_signal_ctrl: RTL and testbench

ADAPTIVE_SIGNAL_CTRL -- requirements
Module: adaptive_signal_ctrl

---
 rtl/tl_pkg.sv | 35 +++
 rtl/phase_timer.sv | 45 ++++
 rtl/adaptive_signal_ctrl.sv | 142 ++++++++++++++
 tb/tb_adaptive_signal_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the adaptive traffic signal controller: state/phase
// codes, light encodings and the routing context carried between phases.
package tl_pkg;

  // Enum values double as the externally visible phase codes.
  typedef enum logic [3:0] {
    ST_INIT  = 4'd0,
    ST_M_G   = 4'd1,
    ST_M_Y   = 4'd2,
    ST_M_L   = 4'd3,
    ST_CLR   = 4'd4,
    ST_S_G   = 4'd5,
    ST_S_Y   = 4'd6,
    ST_P_G   = 4'd7,
    ST_EMG_M = 4'd8,
    ST_EMG_S = 4'd9
  } state_e;

  localparam logic [3:0] M_GREEN  = 4'b0001;
  localparam logic [3:0] M_YELLOW = 4'b0010;
  localparam logic [3:0] M_LEFT   = 4'b1100;
  localparam logic [3:0] M_RED    = 4'b0100;

  localparam logic [2:0] S_GREEN  = 3'b001;
  localparam logic [2:0] S_YELLOW = 3'b010;
  localparam logic [2:0] S_RED    = 3'b100;

  // Where the cycle goes after the next yellow/all-red.
  typedef struct packed {
    logic left_done;    // main left already served this main window
    logic emg_rel;      // current yellow follows an emergency release
    logic resume_main;  // all-red hands over to main green, else secondary
  } route_t;

endpackage

// File: rtl/phase_timer.sv
// Tick-gated phase timer: duration is latched on load and held for the whole
// phase; done fires on the tick that completes the last unit.
module phase_timer #(
  parameter int TIME_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load,
  input  logic [TIME_W-1:0] dur_in,
  output logic              done,
  output logic [TIME_W-1:0] remain
);

  logic [TIME_W-1:0] timer_q, timer_d;
  logic [TIME_W-1:0] dur_q, dur_d;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    timer_d = timer_q;
    dur_d   = dur_q;
    if (load) begin
      dur_d   = dur_in;
      timer_d = '0;
    end else if (tick && (timer_q < dur_q)) begin
      timer_d = timer_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state so all flops update from pre-edge values.
    if (rst) begin
      timer_q <= '0;
      dur_q   <= '0;
    end else begin
      timer_q <= timer_d;
      dur_q   <= dur_d;
    end
  end

  // A zero duration (untimed phases) never completes.
  assign done   = tick && (dur_q != '0) && (timer_q == dur_q - TIME_W'(1));
  assign remain = dur_q - timer_q;

endmodule

// File: rtl/adaptive_signal_ctrl.sv
// Demand-adaptive two-road signal controller with main left turn, pedestrian
// phase and emergency preemption that always passes through yellow and all-red.
module adaptive_signal_ctrl
  import tl_pkg::*;
#(
  parameter int CNT_W   = 3,
  parameter int TIME_W  = 6,
  parameter int BASE_MG = 20,
  parameter int BASE_ML = 4,
  parameter int BASE_SG = 10,
  parameter int BASE_PG = 8,
  parameter int SHIFT   = 2,
  parameter int MAX_T   = 40,
  parameter int YEL_T   = 3,
  parameter int CLR_T   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [CNT_W-1:0]  main_num,
  input  logic [CNT_W-1:0]  left_num,
  input  logic [CNT_W-1:0]  sec_num,
  input  logic [CNT_W-1:0]  p_num,
  input  logic              m_emergency,
  input  logic              s_emergency,
  output logic [3:0]        m_LRYG,
  output logic [2:0]        s_RYG,
  output logic              ped,
  output logic [3:0]        phase,
  output logic [TIME_W-1:0] remain
);

  localparam int SUM_W = TIME_W + CNT_W;

  state_e            state_q, state_d;
  route_t            route_q, route_d;
  logic              tmr_done;
  logic [TIME_W-1:0] dur_in;
  logic              emg;

  // Sum is formed wide enough that the demand term cannot wrap before clamping.
  function automatic logic [TIME_W-1:0] green_dur(input int base, input logic [CNT_W-1:0] num);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + (SUM_W'(num) << SHIFT);
    if (sum > SUM_W'(MAX_T)) sum = SUM_W'(MAX_T);
    if (sum == '0) sum = SUM_W'(1);
    return sum[TIME_W-1:0];
  endfunction

  assign emg = m_emergency | s_emergency;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  state_d = ST_M_G;
      ST_M_G:   if (emg || tmr_done) state_d = ST_M_Y;
      ST_M_Y:   if (tmr_done) state_d = (emg || route_q.emg_rel || route_q.left_done ||
                                         left_num == '0) ? ST_CLR : ST_M_L;
      ST_M_L:   if (emg) state_d = ST_M_Y;
                else if (tmr_done) state_d = ST_CLR;
      ST_CLR:   if (tmr_done) begin
                  if (m_emergency)            state_d = ST_EMG_M;
                  else if (s_emergency)       state_d = ST_EMG_S;
                  else if (route_q.resume_main) state_d = ST_M_G;
                  else                        state_d = ST_S_G;
                end
      ST_S_G:   if (emg || tmr_done) state_d = ST_S_Y;
      ST_S_Y:   if (tmr_done) state_d = (emg || route_q.emg_rel || p_num == '0) ? ST_CLR : ST_P_G;
      ST_P_G:   if (emg || tmr_done) state_d = ST_CLR;
      ST_EMG_M: if (!m_emergency) state_d = ST_M_Y;
      ST_EMG_S: if (!s_emergency) state_d = ST_S_Y;
      default:  state_d = ST_CLR;
    endcase
  end

  // Routing context and the duration to latch, both keyed on the phase being entered.
  always_comb begin
    route_d = route_q;
    dur_in  = '0;
    case (state_d)
      ST_M_G: begin
        route_d.left_done = 1'b0;
        dur_in = green_dur(BASE_MG, main_num);
      end
      ST_M_L: begin
        route_d.left_done = 1'b1;
        dur_in = green_dur(BASE_ML, left_num);
      end
      ST_S_G: dur_in = green_dur(BASE_SG, sec_num);
      ST_P_G: dur_in = green_dur(BASE_PG, p_num);
      ST_M_Y, ST_S_Y: begin
        if (state_q == ST_EMG_M || state_q == ST_EMG_S) route_d.emg_rel = 1'b1;
        dur_in = TIME_W'(YEL_T);
      end
      ST_CLR: begin
        route_d.resume_main = route_q.emg_rel || state_q == ST_S_Y || state_q == ST_P_G;
        route_d.emg_rel     = 1'b0;
        dur_in = TIME_W'(CLR_T);
      end
      default: dur_in = '0;
    endcase
  end

  phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .load   (state_d != state_q),
    .dur_in (dur_in),
    .done   (tmr_done),
    .remain (remain)
  );

  always_comb begin
    m_LRYG = M_RED;
    s_RYG  = S_RED;
    ped    = 1'b0;
    phase  = state_q;
    case (state_q)
      ST_M_G:   m_LRYG = M_GREEN;
      ST_M_Y:   m_LRYG = M_YELLOW;
      ST_M_L:   m_LRYG = M_LEFT;
      ST_S_G:   s_RYG  = S_GREEN;
      ST_S_Y:   s_RYG  = S_YELLOW;
      ST_P_G:   ped    = 1'b1;
      ST_EMG_M: m_LRYG = M_GREEN;
      ST_EMG_S: s_RYG  = S_GREEN;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_adaptive_signal_ctrl.sv
// Directed bench for adaptive_signal_ctrl: phase lengths, light decode,
// saturation, skips, preemption and reset override against hand-computed values.
module tb_adaptive_signal_ctrl;
  import tl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] main_num = '0, left_num = '0, sec_num = '0, p_num = '0;
  logic       m_emergency = 1'b0, s_emergency = 1'b0;
  logic [3:0] m_LRYG;
  logic [2:0] s_RYG;
  logic       ped;
  logic [3:0] phase;
  logic [5:0] remain;

  int n_checks = 0;
  int n_fail   = 0;

  adaptive_signal_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick),
    .main_num(main_num), .left_num(left_num), .sec_num(sec_num), .p_num(p_num),
    .m_emergency(m_emergency), .s_emergency(s_emergency),
    .m_LRYG(m_LRYG), .s_RYG(s_RYG), .ped(ped), .phase(phase), .remain(remain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Expected {m_LRYG, s_RYG, ped} for each phase code.
  function automatic logic [7:0] exp_lights(input logic [3:0] ph);
    case (ph)
      4'd1:    return {4'b0001, 3'b100, 1'b0};
      4'd2:    return {4'b0010, 3'b100, 1'b0};
      4'd3:    return {4'b1100, 3'b100, 1'b0};
      4'd5:    return {4'b0100, 3'b001, 1'b0};
      4'd6:    return {4'b0100, 3'b010, 1'b0};
      4'd7:    return {4'b0100, 3'b100, 1'b1};
      4'd8:    return {4'b0001, 3'b100, 1'b0};
      4'd9:    return {4'b0100, 3'b001, 1'b0};
      default: return {4'b0100, 3'b100, 1'b0};
    endcase
  endfunction

  // Called at the first negedge of a phase; leaves at the first negedge of the next.
  task automatic measure(input logic [3:0] ph, input int len, input string tag);
    int cnt = 0;
    int bad = 0;
    check({tag, " phase"}, phase, ph);
    check({tag, " remain"}, remain, len);
    while (phase == ph && cnt < 200) begin
      if ({m_LRYG, s_RYG, ped} !== exp_lights(ph)) bad++;
      cnt++;
      @(negedge clk);
    end
    check({tag, " len"}, cnt, len);
    check({tag, " lights"}, bad, 0);
  endtask

  task automatic hold(input logic [3:0] ph, input int n, input string tag);
    int bad = 0;
    check({tag, " remain"}, remain, 0);
    for (int i = 0; i < n; i++) begin
      if (phase !== ph || {m_LRYG, s_RYG, ped} !== exp_lights(ph)) bad++;
      @(negedge clk);
    end
    check({tag, " held"}, bad, 0);
  endtask

  // Tick and emergencies are high during reset to show that reset overrides them.
  task automatic do_reset(input logic tick_after, input string tag);
    rst = 1'b1;
    tick = 1'b1;
    m_emergency = 1'b1;
    s_emergency = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, " rst phase"}, phase, 0);
    check({tag, " rst lights"}, {m_LRYG, s_RYG, ped}, {4'b0100, 3'b100, 1'b0});
    check({tag, " rst remain"}, remain, 0);
    m_emergency = 1'b0;
    s_emergency = 1'b0;
    rst = 1'b0;
    tick = tick_after;
    @(negedge clk);
    check({tag, " init one cycle"}, phase, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    @(negedge clk);

    // Full normal cycle with demand on every approach.
    main_num = 3'd2; left_num = 3'd1; sec_num = 3'd1; p_num = 3'd1;
    do_reset(1'b1, "norm");
    measure(4'd1, 28, "norm m_g");
    measure(4'd2, 3,  "norm m_y");
    measure(4'd3, 8,  "norm m_l");
    measure(4'd4, 1,  "norm clr1");
    measure(4'd5, 14, "norm s_g");
    measure(4'd6, 3,  "norm s_y");
    measure(4'd7, 12, "norm p_g");
    measure(4'd4, 1,  "norm clr2");
    check("norm wrap", phase, 1);

    // Saturation at MAX_T, duration unaffected by a mid-phase demand change.
    main_num = 3'd7;
    do_reset(1'b1, "sat");
    check("sat remain", remain, 40);
    cnt = 0;
    repeat (10) begin
      cnt++;
      @(negedge clk);
    end
    main_num = 3'd0;
    check("sat remain mid", remain, 30);
    while (phase == 4'd1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("sat m_g len", cnt, 40);
    measure(4'd2, 3, "sat m_y");

    // Skips, with the timer frozen while tick is low.
    main_num = '0; left_num = '0; sec_num = '0; p_num = '0;
    do_reset(1'b0, "skip");
    repeat (4) @(negedge clk);
    check("skip frozen phase", phase, 1);
    check("skip frozen remain", remain, 20);
    tick = 1'b1;
    measure(4'd1, 20, "skip m_g");
    measure(4'd2, 3,  "skip m_y");
    measure(4'd4, 1,  "skip clr1");
    measure(4'd5, 10, "skip s_g");
    measure(4'd6, 3,  "skip s_y");
    measure(4'd4, 1,  "skip clr2");
    check("skip wrap", phase, 1);

    // Secondary emergency preempting main green.
    main_num = 3'd2; left_num = 3'd1; sec_num = 3'd1; p_num = 3'd1;
    do_reset(1'b1, "pre");
    repeat (5) @(negedge clk);
    s_emergency = 1'b1;
    @(negedge clk);
    measure(4'd2, 3, "pre m_y");
    measure(4'd4, 1, "pre clr");
    check("pre emg_s", phase, 9);
    hold(4'd9, 20, "pre emg_s");
    s_emergency = 1'b0;
    @(negedge clk);
    measure(4'd6, 3, "pre s_y");
    measure(4'd4, 1, "pre clr2");
    check("pre resume", phase, 1);

    // Simultaneous requests during secondary green: main wins; then reset aborts.
    main_num = '0; left_num = '0; sec_num = 3'd1; p_num = '0;
    do_reset(1'b1, "sim");
    measure(4'd1, 20, "sim m_g");
    measure(4'd2, 3,  "sim m_y");
    measure(4'd4, 1,  "sim clr");
    check("sim s_g", phase, 5);
    repeat (2) @(negedge clk);
    m_emergency = 1'b1;
    s_emergency = 1'b1;
    @(negedge clk);
    measure(4'd6, 3, "sim s_y");
    measure(4'd4, 1, "sim clr2");
    check("sim emg_m", phase, 8);
    hold(4'd8, 5, "sim emg_m");
    rst = 1'b1;
    @(negedge clk);
    check("sim rst phase", phase, 0);
    check("sim rst lights", {m_LRYG, s_RYG, ped}, {4'b0100, 3'b100, 1'b0});
    check("sim rst remain", remain, 0);
    rst = 1'b0;
    m_emergency = 1'b0;
    s_emergency = 1'b0;
    @(negedge clk);
    check("sim after rst", phase, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
